scene_sequencer: RTL and testbench
==================================

Name: scene_sequencer

Overview:
- Top-level scene controller for the VGA output path.
- Selects which scene image source (title/start, game, game-over) drives the screen, and sequences transitions with a frame-timed fade-out/fade-in.
- Applies brightness scaling and active-area blanking to the selected pixel, and registers the final 12-bit RGB.
- Sits between the per-scene pixel generators (start scene ROM reader, game renderer, game-over renderer) and the VGA pins; issues a one-cycle reset pulse to game logic on entry to the game scene.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- FADE_FRAMES, 2, frames per fade step (1..255)
- LEVEL_MAX, 16, full-brightness fade level (fixed at 16; scaling uses >>4)

Ports:
- clk  in  1  system clock; h_cnt/v_cnt are synchronous to it
- rst_n  in  1  asynchronous, active-low reset
- h_cnt  in  10  current horizontal pixel count
- v_cnt  in  10  current vertical line count
- start_btn  in  1  one-cycle pulse, debounced start request
- game_over  in  1  one-cycle pulse from game logic
- restart_btn  in  1  one-cycle pulse, debounced return-to-title request
- start_rgb  in  12  title-scene pixel {R4,G4,B4}
- game_rgb  in  12  game-scene pixel
- over_rgb  in  12  game-over-scene pixel
- vga_data  out  12  registered, faded, blanked pixel
- scene_sel  out  2  0=START, 1=GAME, 2=OVER (3 unused)
- busy  out  1  high while any fade is in progress
- game_rst  out  1  one-cycle pulse when scene_sel changes to GAME

Behaviour:
- Reset values (async, rst_n=0): state=SHOW, scene_sel=0, target=0, level=16, frame_div=0, vga_data=0, busy=0, game_rst=0, vsync_flag_q=0.
- Frame tick:
  - flag = (v_cnt >= V_ACTIVE); register it each cycle as vsync_flag_q.
  - tick = flag & ~vsync_flag_q, i.e. exactly one cycle per frame at the start of vertical blanking.
- Fade stepping:
  - frame_div counts ticks while in FADE_OUT/FADE_IN.
  - On a tick with frame_div==FADE_FRAMES-1: frame_div<=0 and level steps by ±1.
  - Otherwise, on a tick, frame_div increments.
  - frame_div clears on every state change.
- FSM states: SHOW, FADE_OUT, FADE_IN.
  - SHOW, scene 0: start_btn -> target=1, FADE_OUT.
  - SHOW, scene 1: game_over -> target=2, FADE_OUT.
  - SHOW, scene 2: restart_btn -> target=0, FADE_OUT.
  - In SHOW, all other request pulses are ignored, and no request is queued.
  - FADE_OUT: level decrements per step. When level reaches 0, in the same cycle as that level update:
    - scene_sel<=target;
    - state<=FADE_IN;
    - game_rst=1 for one cycle if target==1.
  - FADE_IN: level increments per step; at 16 -> SHOW.
  - All button and game_over pulses during FADE_OUT/FADE_IN are dropped.
- busy = (state != SHOW), registered together with state.
- Simultaneous pulses in SHOW: only the pulse relevant to the current scene acts (e.g. game_over and start_btn together in scene 0 -> start_btn acts).
- Full transition duration: 32*FADE_FRAMES ticks; level monotone 16->0->16 with no skipped values.
- Pixel path, 1-cycle latency:
  - src is chosen by scene_sel (3 -> 12'h000).
  - Each 4-bit channel c -> (c*level)>>4, with 9-bit intermediate; level=16 is the identity, level=0 gives black.
  - If h_cnt>=H_ACTIVE or v_cnt>=V_ACTIVE, vga_data<=0.
  - The level and scene_sel used are the registered values in the same cycle as the pixel sample.
- Reset mid-fade returns immediately to SHOW/scene 0/level 16; no game_rst is issued.

Decomposition:
- Shared package constants:
  - scene codes SCENE_START=0, SCENE_GAME=1, SCENE_OVER=2;
  - FSM state encodings;
  - LEVEL_MAX=16;
  - H_ACTIVE/V_ACTIVE defaults, shared with the VGA controller and scene renderers.
- One natural sub-module: rgb_fader, combinational per-channel 4x5 multiply and shift for the 12-bit pixel, instantiated once before the output register.

Test Plan:
- Reset with all *_rgb=12'hFFF, h_cnt=10, v_cnt=10 -> vga_data=12'h000 during reset, 12'hFFF one cycle after the first clk edge; scene_sel=0, busy=0.
- start_btn pulse in scene 0 with FADE_FRAMES=2 -> busy=1 next cycle; level reaches 0 after 32 frame ticks; scene_sel=1 and game_rst high for exactly one cycle; SHOW after 64 ticks total.
- Fade value check at level 8, start_rgb=12'hF84 -> vga_data=12'h742.
- h_cnt=640 or v_cnt=480 with game_rgb=12'hABC -> vga_data=12'h000; frame tick fires once on v_cnt 479->480, not again while v_cnt>480.
- game_over pulse during FADE_IN into scene 1 -> ignored: scene stays 1, busy drops at level 16; a later game_over in SHOW goes to scene 2 and does not pulse game_rst.
- rst_n low mid FADE_OUT at level 5 (async, between edges) -> outputs are immediately scene_sel=0, busy=0, vga_data=0; after release, level=16.

Source files
------------

// File: rtl/scene_sequencer_pkg.sv
// Shared scene-controller constants: scene codes, FSM encodings, fade levels
// and the default visible-area geometry shared with the VGA timing and renderers.
package scene_sequencer_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int LEVEL_W = 5;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 5'd16;

  localparam logic [1:0] SCENE_START = 2'd0;
  localparam logic [1:0] SCENE_GAME  = 2'd1;
  localparam logic [1:0] SCENE_OVER  = 2'd2;

  typedef enum logic [1:0] {
    ST_SHOW     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_FADE_IN  = 2'd2
  } state_e;

endpackage

// File: rtl/scene_sequencer_fader.sv
// Combinational brightness scaler: each colour channel becomes (c*level)>>4,
// so level 16 passes the pixel through and level 0 is black.
module rgb_fader
  import scene_sequencer_pkg::*;
#(
  parameter int NUM_LANES = 3,
  parameter int VEC_W     = 4
) (
  input  logic [NUM_LANES-1:0][VEC_W-1:0] pix,
  input  logic [LEVEL_W-1:0]              level,
  output logic [NUM_LANES-1:0][VEC_W-1:0] pix_out
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [VEC_W+LEVEL_W-1:0] prod;
    assign prod       = {{LEVEL_W{1'b0}}, pix[i]} * {{VEC_W{1'b0}}, level};
    assign pix_out[i] = VEC_W'(prod >> 4);
  end

endmodule

// File: rtl/scene_sequencer.sv
// Scene selector for the VGA path: picks the active scene source, runs the
// frame-timed fade-out/fade-in between scenes and registers the final pixel.
module scene_sequencer
  import scene_sequencer_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int FADE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        start_btn,
  input  logic        game_over,
  input  logic        restart_btn,
  input  logic [11:0] start_rgb,
  input  logic [11:0] game_rgb,
  input  logic [11:0] over_rgb,
  output logic [11:0] vga_data,
  output logic [1:0]  scene_sel,
  output logic        busy,
  output logic        game_rst
);

  localparam logic [9:0] H_LIM   = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM   = 10'(V_ACTIVE);
  localparam logic [7:0] FD_LAST = 8'(FADE_FRAMES - 1);

  state_e               state_q, state_d;
  logic [1:0]           scene_q, scene_d;
  logic [1:0]           target_q, target_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [7:0]           div_q, div_d;
  logic                 busy_d, game_rst_d;
  logic                 vsync_flag_q;
  logic                 flag, tick, step;
  logic [11:0]          src, faded;

  // One tick per frame, on entry to vertical blanking.
  assign flag = (v_cnt >= V_LIM);
  assign tick = flag & ~vsync_flag_q;
  assign step = tick && (div_q == FD_LAST);

  always_comb begin
    state_d    = state_q;
    scene_d    = scene_q;
    target_d   = target_q;
    level_d    = level_q;
    div_d      = div_q;
    game_rst_d = 1'b0;
    case (state_q)
      ST_SHOW: begin
        if (scene_q == SCENE_START && start_btn) begin
          target_d = SCENE_GAME;
          state_d  = ST_FADE_OUT;
        end else if (scene_q == SCENE_GAME && game_over) begin
          target_d = SCENE_OVER;
          state_d  = ST_FADE_OUT;
        end else if (scene_q == SCENE_OVER && restart_btn) begin
          target_d = SCENE_START;
          state_d  = ST_FADE_OUT;
        end
      end
      ST_FADE_OUT: begin
        if (step) begin
          div_d   = '0;
          level_d = level_q - 1'b1;
          // Scene swaps on the same update that reaches black.
          if (level_q == 5'd1) begin
            scene_d    = target_q;
            state_d    = ST_FADE_IN;
            game_rst_d = (target_q == SCENE_GAME);
          end
        end else if (tick) begin
          div_d = div_q + 1'b1;
        end
      end
      ST_FADE_IN: begin
        if (step) begin
          div_d   = '0;
          level_d = level_q + 1'b1;
          if (level_q == LEVEL_MAX - 1'b1) state_d = ST_SHOW;
        end else if (tick) begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_SHOW;
    endcase
    if (state_d != state_q) div_d = '0;
    busy_d = (state_d != ST_SHOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SHOW;
      scene_q      <= SCENE_START;
      target_q     <= SCENE_START;
      level_q      <= LEVEL_MAX;
      div_q        <= '0;
      busy         <= 1'b0;
      game_rst     <= 1'b0;
      vsync_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      scene_q      <= scene_d;
      target_q     <= target_d;
      level_q      <= level_d;
      div_q        <= div_d;
      busy         <= busy_d;
      game_rst     <= game_rst_d;
      vsync_flag_q <= flag;
    end
  end

  always_comb begin
    src = 12'h000;
    case (scene_q)
      SCENE_START: src = start_rgb;
      SCENE_GAME:  src = game_rgb;
      SCENE_OVER:  src = over_rgb;
      default:     src = 12'h000;
    endcase
  end

  rgb_fader #(.NUM_LANES(3), .VEC_W(4)) u_fader (
    .pix     (src),
    .level   (level_q),
    .pix_out (faded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             vga_data <= 12'h000;
    else if (h_cnt >= H_LIM || v_cnt >= V_LIM) vga_data <= 12'h000;
    else                                    vga_data <= faded;
  end

  assign scene_sel = scene_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed bench for scene_sequencer: pixel table in the title scene, then
// hand-written fade, tick-edge, drop-request and async-reset sequences.
module tb_scene_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  h_cnt, v_cnt;
  logic        start_btn, game_over, restart_btn;
  logic [11:0] start_rgb, game_rgb, over_rgb;
  logic [11:0] vga_data;
  logic [1:0]  scene_sel;
  logic        busy, game_rst;

  int n_cmp  = 0;
  int n_err  = 0;
  int gr_cnt = 0;

  typedef struct {
    logic [11:0] srgb, grgb, orgb;
    logic [9:0]  h, v;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[7];

  scene_sequencer #(.H_ACTIVE(640), .V_ACTIVE(480), .FADE_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .start_btn(start_btn), .game_over(game_over), .restart_btn(restart_btn),
    .start_rgb(start_rgb), .game_rgb(game_rgb), .over_rgb(over_rgb),
    .vga_data(vga_data), .scene_sel(scene_sel), .busy(busy), .game_rst(game_rst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (game_rst === 1'b1) gr_cnt++;
  endtask

  task automatic tick_hi();
    v_cnt = 10'd480;
    step();
  endtask

  task automatic tick_lo();
    v_cnt = 10'd10;
    step();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_hi();
      tick_lo();
    end
  endtask

  initial begin
    vecs[0] = '{12'hF84, 12'h123, 12'h456, 10'd10,   10'd10,  12'hF84};
    vecs[1] = '{12'h000, 12'hFFF, 12'hFFF, 10'd0,    10'd0,   12'h000};
    vecs[2] = '{12'h5A3, 12'h111, 12'h222, 10'd639,  10'd479, 12'h5A3};
    vecs[3] = '{12'hFFF, 12'hFFF, 12'hFFF, 10'd640,  10'd10,  12'h000};
    vecs[4] = '{12'hFFF, 12'hFFF, 12'hFFF, 10'd10,   10'd480, 12'h000};
    vecs[5] = '{12'h7C1, 12'h333, 12'h444, 10'd1023, 10'd0,   12'h000};
    vecs[6] = '{12'h7C1, 12'h333, 12'h444, 10'd0,    10'd0,   12'h7C1};

    rst_n = 1'b0;
    h_cnt = 10'd10; v_cnt = 10'd10;
    start_btn = 1'b0; game_over = 1'b0; restart_btn = 1'b0;
    start_rgb = 12'hFFF; game_rgb = 12'hFFF; over_rgb = 12'hFFF;
    #2;
    chk("rst_vga", vga_data, 12'h000);
    chk("rst_scene", scene_sel, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_game_rst", game_rst, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vga_held", vga_data, 12'h000);
    rst_n = 1'b1;
    step();
    chk("first_pixel", vga_data, 12'hFFF);

    for (int i = 0; i < 7; i++) begin
      start_rgb = vecs[i].srgb; game_rgb = vecs[i].grgb; over_rgb = vecs[i].orgb;
      h_cnt = vecs[i].h; v_cnt = vecs[i].v;
      step();
      chk($sformatf("vec%0d", i), vga_data, vecs[i].exp);
    end

    // Title -> game; game_over alongside start_btn is irrelevant in scene 0.
    h_cnt = 10'd10; v_cnt = 10'd10;
    start_rgb = 12'hF84; game_rgb = 12'hFFF;
    start_btn = 1'b1; game_over = 1'b1;
    step();
    start_btn = 1'b0; game_over = 1'b0;
    chk("fo_busy", busy, 1'b1);
    chk("fo_scene", scene_sel, 2'd0);
    ticks(16);
    chk("fade_l8", vga_data, 12'h742);
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    chk("fo_busy_drop", busy, 1'b1);
    ticks(15);
    chk("fo31_scene", scene_sel, 2'd0);
    chk("fo31_no_rst", gr_cnt, 0);
    tick_hi();
    chk("swap_scene", scene_sel, 2'd1);
    chk("swap_game_rst", game_rst, 1'b1);
    tick_lo();
    chk("game_rst_1cyc", game_rst, 1'b0);
    chk("black_l0", vga_data, 12'h000);
    ticks(8);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    ticks(23);
    chk("fi63_busy", busy, 1'b1);
    tick_hi();
    chk("fi64_busy", busy, 1'b0);
    chk("fi64_scene", scene_sel, 2'd1);
    tick_lo();
    game_rgb = 12'hABC;
    step();
    chk("game_full", vga_data, 12'hABC);
    h_cnt = 10'd640;
    step();
    chk("game_hblank", vga_data, 12'h000);
    h_cnt = 10'd10;
    chk("game_rst_count", gr_cnt, 1);

    // Game -> over; long blanking must yield a single tick.
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    chk("go_busy", busy, 1'b1);
    v_cnt = 10'd479; step();
    v_cnt = 10'd480; step();
    for (int v = 481; v <= 490; v++) begin
      v_cnt = 10'(v);
      step();
    end
    v_cnt = 10'd10; step();
    ticks(1);
    game_rgb = 12'hFFF;
    step();
    chk("single_tick_l15", vga_data, 12'hEEE);
    ticks(62);
    chk("over_scene", scene_sel, 2'd2);
    chk("over_busy", busy, 1'b0);
    chk("over_no_game_rst", gr_cnt, 1);

    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
    chk("over_ignore_start", busy, 1'b0);

    // Over -> title, reset asynchronously at level 5.
    over_rgb = 12'hFFF;
    restart_btn = 1'b1;
    step();
    restart_btn = 1'b0;
    ticks(22);
    chk("fade_l5", vga_data, 12'h444);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_scene", scene_sel, 2'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_vga", vga_data, 12'h000);
    #10;
    rst_n = 1'b1;
    start_rgb = 12'hFFF;
    step();
    chk("post_rst_l16", vga_data, 12'hFFF);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_no_game_rst", gr_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
